// File: rtl/spm_seq_ctrl_pkg.sv
// spm_seq_ctrl_pkg: shared state type and counter sizing for the spm sequencer
package spm_seq_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} spm_seq_state_t;
    function automatic int spm_cnt_w(input int width, input int lat);
        return $clog2(2 * width + lat + 1);
    endfunction
endpackage

// File: rtl/spm_seq_ctrl_if.sv
// spm_seq_ctrl_if: operand request and product response handshakes
interface spm_seq_ctrl_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] mc, mp;
    logic [2*WIDTH-1:0] prod;
    modport master(output in_valid, mc, mp, out_ready, input in_ready, out_valid, prod);
    modport slave(input in_valid, mc, mp, out_ready, output in_ready, out_valid, prod);
endinterface

// File: rtl/spm_prod_collect.sv
// spm_prod_collect: right-shift register gathering the LSB-first serial product
module spm_prod_collect #(parameter int WIDTH = 32) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               bit_in,
    output logic [2*WIDTH-1:0] q
);
    always_ff @(posedge clk)
        q <= (rst || clr) ? '0 : en ? {bit_in, q[2*WIDTH-1:1]} : q;
endmodule

// File: rtl/spm_seq_ctrl.sv
// spm_seq_ctrl: drives a serial-parallel multiplier and returns the full product
// SPM_SEQ_CTRL_SIGNED_EN selects sign extension of the serial multiplier.
module spm_seq_ctrl
    import spm_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    spm_seq_ctrl_if.slave    bus,
    output logic             spm_rst,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    input  logic             spm_p
);
    localparam int N = 2 * WIDTH + LAT;
    localparam int CW = spm_cnt_w(WIDTH, LAT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] LATC = CW'(LAT);

    spm_seq_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] op;
    logic run, clr, fill;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
    assign fill = op[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.in_valid ? CLEAR : IDLE;
            CLEAR:   nxt = RUN;
            RUN:     nxt = (cnt == LAST) ? DONE : RUN;
            default: nxt = bus.out_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        run = state == RUN;
        clr = state == CLEAR;
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
        spm_rst = rst | clr;
        spm_y = run & op[0];
    end

    // op shifts once per RUN cycle, so op[0] walks mp LSB first then the fill bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            op <= '0;
            spm_x <= '0;
        end else begin
            cnt <= run ? cnt + 1'b1 : '0;
            if (state == IDLE && bus.in_valid) begin
                spm_x <= bus.mc;
                op <= bus.mp;
            end else if (run) begin
                op <= {fill, op[WIDTH-1:1]};
            end
        end
    end

    spm_prod_collect #(.WIDTH(WIDTH)) u_collect (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .en(run && cnt >= LATC),
        .bit_in(spm_p),
        .q(bus.prod)
    );
endmodule

// File: tb/tb_spm_seq_ctrl.sv
// tb_spm_seq_ctrl: randomized scoreboard bench with a behavioural spm model
module tb_spm_seq_ctrl;
    localparam int W = 8;
    localparam int LAT = 1;
    localparam int N = 2 * W + LAT;

    logic clk = 0;
    logic rst;
    always #5 clk = ~clk;

    spm_seq_ctrl_if #(.WIDTH(W)) bus();
    logic spm_rst, spm_y, spm_p;
    logic [W-1:0] spm_x;

    spm_seq_ctrl #(.WIDTH(W), .LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .spm_rst(spm_rst),
        .spm_x(spm_x),
        .spm_y(spm_y),
        .spm_p(spm_p)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = -100;
    logic [2*W-1:0] exp_q[$];
    int acc_log[$];
    logic ov_d = 0;

    // serial multiplier: signed parallel operand, one serial bit in, one product bit out a cycle later
    longint acc;
    longint add;
    assign add = spm_y ? longint'($signed(spm_x)) : 64'sd0;
    always @(posedge clk) begin
        if (spm_rst) begin
            acc <= 0;
            spm_p <= 1'b0;
        end else begin
            acc <= (acc + add) >>> 1;
            spm_p <= ((acc + add) & 64'sd1) != 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SPM_SEQ_CTRL_SIGNED_EN
        logic signed [2*W-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
        int k = 0;
        bus.in_valid = 1;
        bus.mc = a;
        bus.mp = b;
        while (!bus.in_ready && k < 200) begin
            step(1);
            k++;
        end
        if (k >= 200) chk("accept_timeout", 0, 1);
        step(1);
        if (!keep) bus.in_valid = 0;
    endtask

    task automatic wait_out();
        int k = 0;
        while (!bus.out_valid && k < 200) begin
            step(1);
            k++;
        end
        if (k >= 200) chk("out_timeout", 0, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            ov_d = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_prod(bus.mc, bus.mp));
                acc_cyc = cyc;
                acc_log.push_back(cyc);
            end
            if (spm_rst || cyc == acc_cyc + 1) chk("spm_rst_pulse", spm_rst, cyc == acc_cyc + 1);
            if (bus.out_valid && !ov_d) chk("latency", cyc - acc_cyc, N + 2);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("prod", bus.prod, exp_q.pop_front());
            end
            ov_d = bus.out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        logic [2*W-1:0] p0;
        int k;
        rst = 1;
        bus.in_valid = 0;
        bus.out_ready = 0;
        bus.mc = 0;
        bus.mp = 0;
        step(3);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_prod", bus.prod, 0);
        chk("rst_spm_x", spm_x, 0);
        chk("rst_spm_y", spm_y, 0);
        chk("rst_spm_rst", spm_rst, 1);
        rst = 0;
        bus.out_ready = 1;
        step(1);

        run_op(8'd3, 8'd5, 0);
        wait_out();
        chk("prod_3x5", bus.prod, 16'h000F);
        step(1);
`ifdef SPM_SEQ_CTRL_SIGNED_EN
        run_op(8'hFD, 8'h05, 0);
        wait_out();
        chk("prod_m3x5", bus.prod, 16'hFFF1);
        step(1);
        run_op(8'h7F, 8'h80, 0);
        wait_out();
        chk("prod_7fx80", bus.prod, 16'hC080);
        step(1);
`else
        run_op(8'h7F, 8'hFF, 0);
        wait_out();
        chk("prod_7fxff", bus.prod, 16'h7E81);
        step(1);
`endif

        bus.out_ready = 0;
        run_op(8'h35, 8'h4B, 0);
        wait_out();
        p0 = bus.prod;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_prod", bus.prod, p0);
            chk("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = (i == 1);
            bus.mc = 8'd9;
            bus.mp = 8'd3;
            step(1);
        end
        bus.in_valid = 0;
        chk("bp_spm_x", spm_x, 8'h35);
        bus.out_ready = 1;
        step(1);
        chk("bp_idle", bus.in_ready, 1);
        step(1);

        run_op(8'h21, 8'h6C, 0);
        step(7);
        rst = 1;
        step(1);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_prod", bus.prod, 0);
        rst = 0;
        run_op(8'd2, 8'd7, 0);
        wait_out();
        chk("prod_2x7", bus.prod, 16'h000E);
        step(1);

        acc_log.delete();
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
`ifndef SPM_SEQ_CTRL_SIGNED_EN
            a[W-1] = 1'b0;
`endif
            run_op(a, b, i < 2);
        end
        wait_out();
        step(1);
        chk("b2b_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("b2b_gap0", acc_log[1] - acc_log[0], 2 * W + LAT + 3);
            chk("b2b_gap1", acc_log[2] - acc_log[1], 2 * W + LAT + 3);
        end

        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
`ifndef SPM_SEQ_CTRL_SIGNED_EN
            a[W-1] = 1'b0;
`endif
            bus.out_ready = 0;
            run_op(a, b, 0);
            wait_out();
            step($urandom_range(0, 4));
            bus.out_ready = 1;
            step(1);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step(1);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
